qos_wrr_arbiter: RTL and testbench

// - Downstream stage of the class-demux VC FIFOs: drains the four VC FIFOs (P0..P3) with

---
 rtl/qos_pkg.sv | 13 +
 rtl/qos_rr_pick.sv | 20 ++
 rtl/qos_wrr_arbiter.sv | 92 +++++++++
 tb/tb_qos_wrr_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// qos_pkg: shared constants, FSM state and weight types for the QoS WRR arbiter.
package qos_pkg;
    localparam int NUM_VC   = 4;
    localparam int WORD_W   = 12;
    localparam int DEST_MSB = WORD_W - 1;
    localparam int DEST_LSB = WORD_W - 2;
    typedef enum logic {IDLE, RUN} state_e;
    typedef logic [2:0] weight_t;
    localparam weight_t W0_DEF = 3'd4;
    localparam weight_t W1_DEF = 3'd3;
    localparam weight_t W2_DEF = 3'd2;
    localparam weight_t W3_DEF = 3'd1;
endpackage

// File: rtl/qos_rr_pick.sv
// qos_rr_pick: rotating-priority encoder, scans ptr+1, ptr+2, ptr+3 and finally ptr itself.
module qos_rr_pick
    import qos_pkg::*;
(
    input  logic [NUM_VC-1:0] eligible_i,
    input  logic [1:0]        ptr_i,
    output logic              gnt_valid_o,
    output logic [1:0]        gnt_idx_o
);
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o = ptr_i;
        // descending scan so the nearest candidate after ptr wins last
        for (int k = NUM_VC; k >= 1; k--)
            if (eligible_i[ptr_i + 2'(k)]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o = ptr_i + 2'(k);
            end
    end
endmodule

// File: rtl/qos_wrr_arbiter.sv
// qos_wrr_arbiter: weighted round-robin drain of four VC FIFOs into per-class output FIFOs.
// QOS_WRR_WEIGHTS_EN enables W0..W3; without it every weight is 1 (plain round robin).
module qos_wrr_arbiter
    import qos_pkg::*;
#(
    parameter int      WORD_W = 12,
    parameter weight_t W0 = W0_DEF,
    parameter weight_t W1 = W1_DEF,
    parameter weight_t W2 = W2_DEF,
    parameter weight_t W3 = W3_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active_in,
    input  logic [3:0]        vc_empty,
    input  logic [WORD_W-1:0] vc_data0,
    input  logic [WORD_W-1:0] vc_data1,
    input  logic [WORD_W-1:0] vc_data2,
    input  logic [WORD_W-1:0] vc_data3,
    output logic [3:0]        vc_pop,
    input  logic [3:0]        out_afull,
    output logic [3:0]        out_push,
    output logic [WORD_W-1:0] out_data,
    output logic              arb_busy
);
`ifdef QOS_WRR_WEIGHTS_EN
    localparam bit WRR_EN = 1'b1;
`else
    localparam bit WRR_EN = 1'b0;
`endif
    localparam weight_t WT [NUM_VC] = '{WRR_EN ? W0 : weight_t'(1), WRR_EN ? W1 : weight_t'(1),
                                        WRR_EN ? W2 : weight_t'(1), WRR_EN ? W3 : weight_t'(1)};

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    weight_t           credit_q, credit_d;
    logic [3:0]        push_q, push_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] head [NUM_VC];
    logic [NUM_VC-1:0] elig;
    logic              run, stay, pick_v, gnt_v;
    logic [1:0]        pick_idx, gnt_idx;

    assign head = '{vc_data0, vc_data1, vc_data2, vc_data3};
    // pops are suppressed while reset is high so the VC FIFOs keep their words
    assign run = state_q == RUN && active_in && !reset;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_VC; i++)
            elig[i] = run && !vc_empty[i] && !out_afull[head[i][WORD_W-1 -: 2]];
    end

    qos_rr_pick u_pick (
        .eligible_i (elig),
        .ptr_i      (ptr_q),
        .gnt_valid_o(pick_v),
        .gnt_idx_o  (pick_idx)
    );

    always_comb begin
        state_d = active_in ? RUN : IDLE;
        stay = elig[ptr_q] && credit_q != 3'd0;
        gnt_v = stay || pick_v;
        gnt_idx = stay ? ptr_q : pick_idx;
        ptr_d = gnt_v ? gnt_idx : ptr_q;
        credit_d = stay ? credit_q - 3'd1 : pick_v ? WT[pick_idx] - 3'd1 : credit_q;
        vc_pop = gnt_v ? 4'b0001 << gnt_idx : 4'b0000;
        push_d = gnt_v ? 4'b0001 << head[gnt_idx][WORD_W-1 -: 2] : 4'b0000;
        data_d = gnt_v ? head[gnt_idx] : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            credit_q <= WT[0];
            push_q   <= 4'b0000;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            push_q   <= push_d;
            data_q   <= data_d;
        end
    end

    assign out_push = push_q;
    assign out_data = data_q;
    assign arb_busy = |push_q || |elig;
endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// tb_qos_wrr_arbiter: table-driven and directed checks of the QoS WRR arbiter with modelled VC FIFOs.
module tb_qos_wrr_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active_in = 1'b0;
    logic [3:0]  vc_empty = 4'hF;
    logic [11:0] vd [4];
    logic [3:0]  vc_pop;
    logic [3:0]  out_afull = 4'h0;
    logic [3:0]  out_push;
    logic [11:0] out_data;
    logic        arb_busy;

    logic [11:0] mem [4][16];
    int          hd [4];
    int          tl [4];
    int          pass = 0;
    int          total = 0;

`ifdef QOS_WRR_WEIGHTS_EN
    localparam int REL_BOUND = 3 + 2 + 1 + 1;
`else
    localparam int REL_BOUND = 1 + 1 + 1 + 1;
`endif

    typedef struct {
        logic        act;
        logic [3:0]  afull;
        logic [3:0]  pop;
        logic        busy;
        logic [3:0]  push;
        logic [11:0] data;
    } vec_t;

    qos_wrr_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .active_in(active_in),
        .vc_empty (vc_empty),
        .vc_data0 (vd[0]),
        .vc_data1 (vd[1]),
        .vc_data2 (vd[2]),
        .vc_data3 (vd[3]),
        .vc_pop   (vc_pop),
        .out_afull(out_afull),
        .out_push (out_push),
        .out_data (out_data),
        .arb_busy (arb_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        else pass++;
    endtask

    function automatic int idx(input logic [3:0] p);
        idx = 9;
        for (int i = 3; i >= 0; i--) if (p[i]) idx = i;
    endfunction

    function automatic int wrr_exp(input int k);
`ifdef QOS_WRR_WEIGHTS_EN
        int s;
        s = k % 10;
        return s < 4 ? 0 : s < 7 ? 1 : s < 9 ? 2 : 3;
`else
        return k % 4;
`endif
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            vc_empty[i] = hd[i] == tl[i];
            vd[i] = vc_empty[i] ? 12'h000 : mem[i][hd[i]];
        end
    endtask

    task automatic qclear();
        for (int i = 0; i < 4; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
    endtask

    task automatic qpush(input int i, input logic [11:0] w);
        mem[i][tl[i]] = w;
        tl[i]++;
    endtask

    task automatic fill(input int n);
        qclear();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < n; k++) qpush(i, {2'(i + k), 10'h05A + 10'(i * 16 + k)});
        drive();
    endtask

    // one clock: sample pop/busy before the edge, retire popped words after it
    task automatic tick(output logic [3:0] p, output logic [11:0] w, output logic b);
        #1;
        p = vc_pop;
        b = arb_busy;
        w = 12'h000;
        total++;
        if (!$onehot0(p) || (p != 4'h0 && hd[idx(p)] == tl[idx(p)]))
            $display("FAIL pop_legal got=%b want=onehot0_nonempty", p);
        else pass++;
        for (int i = 0; i < 4; i++) if (p[i]) w = mem[i][hd[i]];
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (p[i]) hd[i]++;
        drive();
    endtask

    task automatic reset_dut();
        logic [3:0] p;
        logic [11:0] w;
        logic b;
        reset = 1'b1;
        active_in = 1'b0;
        out_afull = 4'h0;
        tick(p, w, b);
        tick(p, w, b);
        reset = 1'b0;
    endtask

    task automatic grant_seq(input string nm, input int n, input int k0);
        logic [3:0] p;
        logic [11:0] w;
        logic b;
        for (int k = 0; k < n; k++) begin
            tick(p, w, b);
            chk($sformatf("%s_gnt%0d", nm, k), idx(p), wrr_exp(k0 + k));
            chk($sformatf("%s_push%0d", nm, k), out_push, 4'b0001 << w[11:10]);
            chk($sformatf("%s_data%0d", nm, k), out_data, w);
        end
    endtask

    initial begin
        vec_t tv [7];
        logic [3:0] p;
        logic [11:0] w;
        logic b;
        bit found;
        tv[0] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 12'h000};
        tv[1] = '{1'b1, 4'h0, 4'h1, 1'b1, 4'h1, 12'h0FF};
        tv[2] = '{1'b1, 4'h0, 4'h1, 1'b1, 4'h2, 12'h404};
        tv[3] = '{1'b1, 4'h0, 4'h1, 1'b1, 4'h4, 12'h895};
        tv[4] = '{1'b1, 4'h0, 4'h1, 1'b1, 4'h8, 12'hCAE};
        tv[5] = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 12'h000};
        tv[6] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 12'h000};
        qclear();
        drive();
        reset_dut();
        chk("rst_push", out_push, 4'h0);
        chk("rst_data", out_data, 12'h000);
        chk("rst_busy", arb_busy, 1'b0);
        chk("rst_pop", vc_pop, 4'h0);

        qpush(0, 12'h0FF);
        qpush(0, 12'h404);
        qpush(0, 12'h895);
        qpush(0, 12'hCAE);
        drive();
        for (int r = 0; r < 7; r++) begin
            active_in = tv[r].act;
            out_afull = tv[r].afull;
            tick(p, w, b);
            chk($sformatf("tv_pop%0d", r), p, tv[r].pop);
            chk($sformatf("tv_busy%0d", r), b, tv[r].busy);
            chk($sformatf("tv_push%0d", r), out_push, tv[r].push);
            if (tv[r].push != 4'h0) chk($sformatf("tv_data%0d", r), out_data, tv[r].data);
        end

        reset_dut();
        fill(8);
        active_in = 1'b1;
        tick(p, w, b);
        chk("wrr_entry_pop", p, 4'h0);
        grant_seq("wrr", 20, 0);

        reset_dut();
        qclear();
        qpush(0, 12'h0DC);
        for (int i = 1; i < 4; i++)
            for (int k = 0; k < 8; k++) qpush(i, {2'(i), 10'(k * 8 + i)});
        drive();
        out_afull = 4'b0001;
        active_in = 1'b1;
        tick(p, w, b);
        for (int c = 0; c < 6; c++) begin
            tick(p, w, b);
            chk($sformatf("af_skip%0d", c), p[0], 1'b0);
            chk($sformatf("af_served%0d", c), p != 4'h0, 1'b1);
        end
        out_afull = 4'b0000;
        found = 1'b0;
        for (int c = 0; c < REL_BOUND && !found; c++) begin
            tick(p, w, b);
            found = p[0];
        end
        chk("af_release", found, 1'b1);
        if (found) begin
            chk("af_rel_push", out_push, 4'b0001);
            chk("af_rel_data", out_data, 12'h0DC);
        end

        reset_dut();
        fill(8);
        active_in = 1'b1;
        tick(p, w, b);
        grant_seq("pre_drop", 2, 0);
        active_in = 1'b0;
        #1;
        chk("drop_push_held", out_push != 4'h0, 1'b1);
        tick(p, w, b);
        chk("drop_pop", p, 4'h0);
        chk("drop_busy_pre", b, 1'b1);
        chk("drop_push_after", out_push, 4'h0);
        chk("drop_busy_after", arb_busy, 1'b0);
        tick(p, w, b);
        chk("idle_pop", p, 4'h0);
        tick(p, w, b);
        active_in = 1'b1;
        tick(p, w, b);
        chk("resume_entry_pop", p, 4'h0);
        grant_seq("resume", 3, 2);

        fill(8);
        grant_seq("pre_rst", 2, 5);
        reset = 1'b1;
        tick(p, w, b);
        chk("rst_flight_pop", p, 4'h0);
        chk("rst_flight_push", out_push, 4'h0);
        chk("rst_flight_data", out_data, 12'h000);
        reset = 1'b0;
        tick(p, w, b);
        chk("rst_entry_pop", p, 4'h0);
        grant_seq("post_rst", 5, 0);

        qclear();
        drive();
        tick(p, w, b);
        for (int c = 0; c < 10; c++) begin
            tick(p, w, b);
            chk($sformatf("empty_pop%0d", c), p, 4'h0);
            chk($sformatf("empty_busy%0d", c), b, 1'b0);
            chk($sformatf("empty_push%0d", c), out_push, 4'h0);
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
